// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer
//   Multi-cycle WIDTH-bit adder built around a single 4-bit ripple-carry
//   slice. One nibble is processed per clock, least-significant nibble
//   first. The carry between nibbles is held in a register.
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   start_valid  command valid from the requester
//   start_ready  high in IDLE; the block can accept a command
//   a, b, cin    operands and carry-in, sampled only when a command is accepted
//   res_valid    result valid; high in DONE
//   res_ready    consumer accepts the result
//   sum          A+B+cin modulo 2^WIDTH
//   cout         unsigned carry out of bit WIDTH-1
//   ovf          two's-complement signed overflow
//   busy         high in RUN or DONE
module rca_slice_sequencer #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [4:0]       slice;
    logic             accept;
    logic             last;

    // 4-bit ripple-carry slice: {c4, s4}
    always_comb begin
        slice = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'b0000, carry};
    end

    assign accept = start_valid && (state == IDLE);
    assign last   = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            // Each slice result enters at the top; after NSLICE steps the
            // first nibble has shifted down to bit 0.
            sum   <= {slice[3:0], sum[WIDTH-1:4]};
            opa   <= {4'b0000, opa[WIDTH-1:4]};
            opb   <= {4'b0000, opb[WIDTH-1:4]};
            carry <= slice[4];
            if (last) begin
                // Wrap to 0 so the counter stays within NSLICE-1 even when
                // NSLICE is not a power of two.
                cnt  <= '0;
                cout <= slice[4];
                ovf  <= (opa[3] == opb[3]) && (slice[3] != opa[3]);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
